mult_issue: RTL
===============

MULT_ISSUE -- requirements
Module: mult_issue

Interface
REQ-001 SHALL have parameter A_DW, default 8, multiplicand width.
REQ-002 SHALL have parameter B_DW, default 8, multiplier width.
REQ-003 SHALL have parameter C_DW, default A_DW+B_DW, product width.
REQ-004 SHALL have parameter DEPTH, default 2, operand FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter TIMEOUT, default 64, max cycles from issue to result.
REQ-006 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_vld_i  input  1  operand request valid.
REQ-009 SHALL have port req_rdy_o  output  1  operand request accepted when high with req_vld_i.
REQ-010 SHALL have port req_tc_mode_i  input  2  signed mode; bit0 for a, bit1 for b.
REQ-011 SHALL have ports req_a_i  input  A_DW and req_b_i  input  B_DW, operands.
REQ-012 SHALL have port mul_en_po  output  1  one-cycle start pulse to the shift-accumulate multiplier.
REQ-013 SHALL have ports mul_tc_mode_o  output  2, mul_a_o  output  A_DW, mul_b_o  output  B_DW, operands to multiplier.
REQ-014 SHALL have ports mul_busy_i  input  1, mul_c_vld_i  input  1, mul_c_i  input  C_DW, from multiplier.
REQ-015 SHALL have ports rsp_vld_o  output  1, rsp_rdy_i  input  1, rsp_c_o  output  C_DW, product handshake.
REQ-016 SHALL have port timeout_o  output  1  sticky watchdog error flag.

Function
REQ-017 SHALL buffer requests in a DEPTH-entry FIFO; push on req_vld_i & req_rdy_o; req_rdy_o = FIFO not full, registered-state only (no combinational path from req_vld_i or rsp_rdy_i).
REQ-018 SHALL drive mul_a_o/mul_b_o/mul_tc_mode_o from the FIFO head continuously; head SHALL not change from issue until result capture or timeout.
REQ-019 SHALL implement FSM IDLE, ISSUE, WAIT.
REQ-020 IDLE->ISSUE when FIFO non-empty, mul_busy_i=0, and (rsp_vld_o=0 or rsp_rdy_i=1).
REQ-021 In ISSUE mul_en_po SHALL be 1 for exactly that cycle; ISSUE->WAIT unconditionally.
REQ-022 mul_en_po SHALL never assert while mul_busy_i=1.
REQ-023 In WAIT, on mul_c_vld_i=1: capture mul_c_i into rsp_c_o, set rsp_vld_o next cycle, pop FIFO, go IDLE.
REQ-024 rsp_vld_o SHALL hold with rsp_c_o stable until rsp_rdy_i=1; cleared in the accepting cycle unless a new result is captured that same cycle (then stays 1 with new data).
REQ-025 Push and pop in same cycle SHALL both occur; count unchanged; full FIFO with pop SHALL still report req_rdy_o=0 that cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH; FIFO order strictly preserved.
REQ-027 mul_c_vld_i outside WAIT SHALL be ignored.
REQ-028 Back-to-back throughput: new ISSUE earliest the cycle after return to IDLE.

Reset
REQ-029 On rst_ni=0, asynchronously: FSM=IDLE, FIFO empty, req_rdy_o=1 after release, mul_en_po=0, rsp_vld_o=0, rsp_c_o=0, timeout_o=0, watchdog=0.
REQ-030 Reset mid-WAIT SHALL discard in-flight and buffered operations; later mul_c_vld_i ignored.

Configuration
REQ-031 Macro MULT_ISSUE_TIMEOUT_EN defined: watchdog counts WAIT cycles; reaching TIMEOUT without mul_c_vld_i SHALL set timeout_o (sticky until reset), pop the head, go IDLE, no response generated.
REQ-032 Macro undefined: no watchdog logic; timeout_o tied 0; WAIT waits indefinitely.

Verification
REQ-033 Signed: tc=2'b11, a=8'hFD (-3), b=8'h05, result 16'hFFF1 after multiplier -> rsp_c_o=16'hFFF1, rsp_vld_o=1, one mul_en_po pulse.
REQ-034 Unsigned: tc=2'b00, a=8'hFF, b=8'hFF -> rsp_c_o=16'hFE01.
REQ-035 Three back-to-back requests, DEPTH=2, rsp_rdy_i=1 -> req_rdy_o drops after 2 pushes, responses in order, mul_en_po never while mul_busy_i=1.
REQ-036 rsp_rdy_i=0 for 20 cycles with 2 queued -> second ISSUE withheld; rsp_c_o stable; issue resumes the cycle rsp_rdy_i=1.
REQ-037 With MULT_ISSUE_TIMEOUT_EN, TIMEOUT=16, multiplier stub never returns -> timeout_o=1 on cycle 16 of WAIT, FIFO head popped, next entry issued.
REQ-038 Reset asserted in WAIT, stray mul_c_vld_i after release -> rsp_vld_o stays 0, FIFO empty.

Source files
------------

// File: rtl/mult_issue.sv
// Operand FIFO and issue sequencer for a shift-accumulate multiplier.
// Optional watchdog enabled by defining MULT_ISSUE_TIMEOUT_EN.
module mult_issue #(
    parameter int unsigned A_DW    = 8,
    parameter int unsigned B_DW    = 8,
    parameter int unsigned C_DW    = A_DW + B_DW,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_vld_i,
    output logic              req_rdy_o,
    input  logic [1:0]        req_tc_mode_i,
    input  logic [A_DW-1:0]   req_a_i,
    input  logic [B_DW-1:0]   req_b_i,
    output logic              mul_en_po,
    output logic [1:0]        mul_tc_mode_o,
    output logic [A_DW-1:0]   mul_a_o,
    output logic [B_DW-1:0]   mul_b_o,
    input  logic              mul_busy_i,
    input  logic              mul_c_vld_i,
    input  logic [C_DW-1:0]   mul_c_i,
    output logic              rsp_vld_o,
    input  logic              rsp_rdy_i,
    output logic [C_DW-1:0]   rsp_c_o,
    output logic              timeout_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned FW = 2 + A_DW + B_DW;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e          state;
    logic [FW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            wd_fire;

    // Ready depends only on the occupancy register, never on same-cycle inputs.
    assign req_rdy_o = (count != CW'(DEPTH));
    assign push      = req_vld_i && req_rdy_o;
    assign pop       = (state == WAIT) && (mul_c_vld_i || wd_fire);

    assign {mul_tc_mode_o, mul_a_o, mul_b_o} = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {req_tc_mode_i, req_a_i, req_b_i};
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue sequencer and response register; a held response blocks the next issue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            mul_en_po <= 1'b0;
            rsp_vld_o <= 1'b0;
            rsp_c_o   <= '0;
        end else begin
            mul_en_po <= 1'b0;
            if (state == WAIT && mul_c_vld_i) begin
                rsp_c_o   <= mul_c_i;
                rsp_vld_o <= 1'b1;
            end else if (rsp_rdy_i) begin
                rsp_vld_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (count != '0 && !mul_busy_i && (!rsp_vld_o || rsp_rdy_i)) begin
                        state     <= ISSUE;
                        mul_en_po <= 1'b1;
                    end
                end
                ISSUE:   state <= WAIT;
                WAIT: begin
                    if (mul_c_vld_i || wd_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT_ISSUE_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_cnt;

    assign wd_fire = (state == WAIT) && !mul_c_vld_i && (wd_cnt == WW'(TIMEOUT - 1));

    // Watchdog counts cycles spent in WAIT; the error flag is sticky until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            wd_cnt    <= (state == WAIT && !pop) ? wd_cnt + WW'(1) : '0;
            timeout_o <= timeout_o | wd_fire;
        end
    end
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule
